// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bi, bo is the borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one bit per RUN cycle.
// Signed overflow flag is built only when SERIAL_SUB_SIGNED_OVF_EN is defined.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic               br_q, br_d, bout_q, bout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               bit_d, bit_bo, last_bit;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  full_subtractor u_fs (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .bi (br_q),
    .d  (bit_d),
    .bo (bit_bo)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        // Difference bits enter at the MSB so the word is aligned after WIDTH shifts.
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        br_d   = bit_bo;
        diff_d = {bit_d, diff_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_bit) begin
          state_d = S_DONE;
          bout_d  = bit_bo;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
          ovf_d   = br_q ^ bit_bo;
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  assign ovf  = ovf_q;
`else
  assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: arithmetic reference model plus directed vectors.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         bin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, bout, ovf;
  logic [W-1:0] diff;

  int errs = 0;
  int checks = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic ovf_en(input logic v);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    return v;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: edge-indexed view of when an operation is accepted and
  // when its result appears, with the result computed by plain arithmetic.
  int           e = 0;
  int           acc_e = -1000;
  bit           pend = 1'b0;
  bit           m_ok = 1'b0;
  logic [W-1:0] ed = '0, sd = '0;
  logic         eb = 1'b0, eo = 1'b0, sb = 1'b0, so = 1'b0;

  initial begin
    bit was_busy;
    int full, s;
    forever begin
      @(posedge clk);
      was_busy = pend && (e >= acc_e) && (e <= acc_e + W);
      e = e + 1;
      if (!rst_n) begin
        pend = 1'b0;
        sd = '0; sb = 1'b0; so = 1'b0;
        m_ok = 1'b1;
      end else if (start && !was_busy) begin
        pend  = 1'b1;
        acc_e = e;
        full  = int'(a) - int'(b) - int'(bin);
        s     = int'($signed(a)) - int'($signed(b)) - int'(bin);
        ed    = full[W-1:0];
        eb    = (full < 0);
        eo    = ovf_en((s < -(2 ** (W - 1))) || (s > (2 ** (W - 1)) - 1));
      end
      if (pend && e == acc_e + W) begin
        sd = ed; sb = eb; so = eo;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      logic xbusy, xdone;
      xbusy = pend && (e >= acc_e) && (e <= acc_e + W);
      xdone = pend && (e == acc_e + W);
      chk("cyc_busy", busy, xbusy);
      chk("cyc_done", done, xdone);
      if (!xbusy || xdone) begin
        chk("cyc_diff", diff, sd);
        chk("cyc_bout", bout, sb);
        chk("cyc_ovf", ovf, so);
      end
    end
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                        input logic [W-1:0] xd, input logic xb, input logic xo,
                        input bit noise, input string nm);
    int n;
    n = 0;
    @(posedge clk); #2;
    a = ta; b = tb_; bin = tbin; start = 1'b1;
    while (n < 3 * W) begin
      @(posedge clk); #2;
      n++;
      start = 1'b0;
      if (noise && n == 4) begin
        start = 1'b1; a = 8'h55; b = 8'hAA; bin = 1'b1;
      end
      if (done === 1'b1) break;
    end
    chk({nm, "_latency"}, n, W + 1);
    chk({nm, "_diff"}, diff, xd);
    chk({nm, "_bout"}, bout, xb);
    chk({nm, "_ovf"}, ovf, xo);
    if (noise) begin
      // start during the DONE cycle must be dropped
      start = 1'b1; a = 8'hC3; b = 8'h3C; bin = 1'b0;
      @(posedge clk); #2;
      start = 1'b0;
      chk({nm, "_ign_busy"}, busy, 1'b0);
      chk({nm, "_ign_done"}, done, 1'b0);
      chk({nm, "_ign_diff"}, diff, xd);
      @(posedge clk); #2;
      chk({nm, "_ign_busy2"}, busy, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_diff", diff, 8'h00);
    chk("rst_bout", bout, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    rst_n = 1'b1;

    run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, "sub_05_03");
    run_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, "sub_03_05");
    run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, "sub_00_00_b");
    run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, ovf_en(1'b1), 1'b0, "sub_80_01");
    run_op(8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0, 1'b0, "sub_7F_01");
    run_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, ovf_en(1'b1), 1'b0, "sub_7F_FF");
    run_op(8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, ovf_en(1'b1), 1'b0, "sub_A5_5A");
    run_op(8'h12, 8'h34, 1'b1, 8'hDD, 1'b1, 1'b0, 1'b1, "noise");

    // abort mid-run with reset, then reset winning over a simultaneous start
    @(posedge clk); #2;
    a = 8'h12; b = 8'h34; bin = 1'b0; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(posedge clk); #2;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_diff", diff, 8'h00);
    chk("abort_bout", bout, 1'b0);
    chk("abort_ovf", ovf, 1'b0);
    start = 1'b1; a = 8'h44; b = 8'h11;
    @(posedge clk); #2;
    chk("rst_prio_busy", busy, 1'b0);
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk("post_rst_idle", busy, 1'b0);

    run_op(8'hFF, 8'h0F, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0, "sub_FF_0F");
    repeat (3) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    errs++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand and difference width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  minuend, captured on accepted start.
REQ-006 SHALL have port b  input  WIDTH  subtrahend, captured on accepted start.
REQ-007 SHALL have port bin  input  1  borrow-in, captured on accepted start.
REQ-008 SHALL have port busy  output  1  high in RUN and DONE states.
REQ-009 SHALL have port done  output  1  single-cycle pulse; result valid.
REQ-010 SHALL have port diff  output  WIDTH  a - b - bin modulo 2^WIDTH.
REQ-011 SHALL have port bout  output  1  borrow-out of MSB stage.
REQ-012 SHALL have port ovf  output  1  signed (two's complement) overflow flag.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE after WIDTH RUN cycles, DONE->IDLE unconditionally after one cycle.
REQ-014 SHALL, on accepting start at edge k, load a, b into shift registers, load borrow register with bin, clear bit counter.
REQ-015 SHALL process exactly one bit per RUN cycle, LSB first: d = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-016 SHALL shift each difference bit into diff from the MSB end so diff is fully aligned after WIDTH shifts.
REQ-017 SHALL assert done for exactly one cycle, in DONE, following edge k+WIDTH; latency start-accept to done = WIDTH+1 cycles.
REQ-018 SHALL hold diff, bout, ovf stable from done until the next accepted start.
REQ-019 SHALL ignore start while busy is high, including start asserted in the DONE cycle; no operand capture occurs.
REQ-020 SHALL accept start in the first IDLE cycle after DONE (back-to-back throughput WIDTH+2 cycles).
REQ-021 SHALL use counter width ceil(log2(WIDTH+1)); counter SHALL NOT wrap within an operation.

Reset
REQ-022 SHALL, when rst_n is low at a clock edge, force state IDLE and busy=0, done=0, diff=0, bout=0, ovf=0, counter=0.
REQ-023 SHALL abort any in-progress operation on reset with no done pulse; the first start after rst_n deasserts SHALL be accepted normally.
REQ-024 SHALL give rst_n priority over start on the same edge.

Configuration
REQ-025 SHALL compile signed-overflow logic only when macro SERIAL_SUB_SIGNED_OVF_EN is defined: ovf = borrow into MSB stage XOR borrow out of MSB stage, captured with the MSB bit.
REQ-026 SHALL, without SERIAL_SUB_SIGNED_OVF_EN, keep port ovf and tie it to constant 0.

Structure
REQ-027 SHALL place the FSM state enum type and the default width constant in shared package serial_sub_pkg.
REQ-028 SHALL instantiate one sub-module full_subtractor (ports d, bo, x, y, bi; purely combinational) for the per-bit stage.

Verification
REQ-029 SHALL cover: a=0x05, b=0x03, bin=0 -> diff=0x02, bout=0, done exactly 9 cycles after start accepted.
REQ-030 SHALL cover: a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1; and a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
REQ-031 SHALL cover (macro defined): a=0x80, b=0x01 -> diff=0x7F, ovf=1; a=0x7F, b=0x01 -> diff=0x7E, ovf=0; macro undefined -> ovf=0 always.
REQ-032 SHALL cover: start pulsed mid-RUN and in DONE cycle with new operands -> ignored, result of original operation unchanged, single done pulse.
REQ-033 SHALL cover: rst_n low at RUN cycle 4 -> all outputs 0, no done; subsequent start a=0xFF, b=0x0F -> diff=0xF0, bout=0.
